// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, pattern types and palette
// Purpose: default 640x480@60 timing constants, pattern mode enum, RGB struct,
//          8-entry colour palette and a counter-width helper.
// Ports:   none (package).
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    VBARS   = 2'd0,
    HBARS   = 2'd1,
    CHECKER = 2'd2,
    RAMP    = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Element 0 is the rightmost entry: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [7:0][23:0] PALETTE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // Counters are at least 8 bits wide so the grey ramp can always use
  // hcount[7:0], even for small test timings.
  function automatic int cnt_width(input int total);
    return ($clog2(total) > 8) ? $clog2(total) : 8;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - pattern request and VGA pixel/sync bundle
// Purpose: groups the mode request and the registered VGA outputs.
// Ports:   master = pattern engine (drives video, reads mode_sel);
//          slave  = display side (reads video, drives mode_sel).
interface vga_pattern_gen_if;
  logic [1:0] mode_sel;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic [1:0] active_mode;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport master (
    input  mode_sel,
    output hsync, vsync, video_on, frame_start, active_mode, red, green, blue
  );

  modport slave (
    output mode_sel,
    input  hsync, vsync, video_on, frame_start, active_mode, red, green, blue
  );
endinterface

// File: rtl/vga_pattern_gen_timing.sv
// rtl/vga_pattern_gen_timing.sv - horizontal/vertical counters and raw timing flags
// Purpose: hcount/vcount raster position, raw active-low syncs, active flags,
//          end-of-line and end-of-frame strobes (all combinational from counters).
// Ports:   clk_25, n_rst in; hcount, vcount, hsync_raw, vsync_raw, h_active,
//          v_active, line_end, frame_end out.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk_25,
  input  logic          n_rst,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          h_active,
  output logic          v_active,
  output logic          line_end,
  output logic          frame_end
);
  localparam logic [HW-1:0] H_LAST     = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (line_end) begin
      hcount <= '0;
      vcount <= frame_end ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  assign line_end  = (hcount == H_LAST);
  assign frame_end = line_end && (vcount == V_LAST);
  assign h_active  = (hcount < H_ACT_END);
  assign v_active  = (vcount < V_ACT_END);
  assign hsync_raw = !((hcount >= HS_START) && (hcount < HS_END));
  assign vsync_raw = !((vcount >= VS_START) && (vcount < VS_END));

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern engine with frame-aligned mode switch
// Purpose: timing generator plus bar/checker/ramp pattern source; every output
//          comes from one register stage so sync, RGB and flags stay aligned.
// Ports:   clk_25 pixel clock, n_rst async active-low reset,
//          vid (master): mode_sel in; hsync, vsync, video_on, frame_start,
//          active_mode, red, green, blue out.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int N_BARS     = 4,
  parameter int CHECK_LOG2 = 5
) (
  input  logic              clk_25,
  input  logic              n_rst,
  vga_pattern_gen_if.master vid
);
  localparam int HW    = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW    = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BAR_W = H_ACTIVE / N_BARS;
  localparam int BAR_H = V_ACTIVE / N_BARS;
  localparam logic [HW-1:0] BAR_W_LAST = HW'(BAR_W - 1);
  localparam logic [VW-1:0] BAR_H_LAST = VW'(BAR_H - 1);

  generate
    if (N_BARS < 2 || N_BARS > 8 || (H_ACTIVE % N_BARS) != 0 ||
        (V_ACTIVE % N_BARS) != 0 || CHECK_LOG2 > 7) begin : g_bad_params
      $error("vga_pattern_gen: illegal N_BARS or CHECK_LOG2");
    end
  endgenerate

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic          hsync_raw, vsync_raw, h_active, v_active, line_end, frame_end;
  logic [HW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [VW-1:0] row_px;
  logic [2:0]    row_idx;
  pattern_mode_t cur_mode;
  rgb_t          pix;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk_25   (clk_25),
    .n_rst    (n_rst),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync_raw(hsync_raw),
    .vsync_raw(vsync_raw),
    .h_active (h_active),
    .v_active (v_active),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  // Column tracker: counts only through the visible part of the line so
  // bar_idx stays within the palette; blanking pixels are forced black anyway.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_active) begin
      if (bar_px == BAR_W_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px  <= bar_px + 1'b1;
      end
    end
  end

  // Row tracker: same idea, stepped once per visible line.
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      row_px  <= '0;
      row_idx <= '0;
    end else if (frame_end) begin
      row_px  <= '0;
      row_idx <= '0;
    end else if (line_end && v_active) begin
      if (row_px == BAR_H_LAST) begin
        row_px  <= '0;
        row_idx <= row_idx + 3'd1;
      end else begin
        row_px  <= row_px + 1'b1;
      end
    end
  end

  // The mode is latched while the counters sit on the last raster position,
  // so it is already valid when the counters show (0,0).
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      cur_mode <= VBARS;
    end else if (frame_end) begin
      cur_mode <= pattern_mode_t'(vid.mode_sel);
    end
  end

  always_comb begin
    pix = '0;
    case (cur_mode)
      VBARS:   pix = rgb_t'(PALETTE[bar_idx]);
      HBARS:   pix = rgb_t'(PALETTE[row_idx]);
      CHECKER: pix = (hcount[CHECK_LOG2] ^ vcount[CHECK_LOG2]) ? rgb_t'(24'hFFFFFF)
                                                               : rgb_t'(24'h000000);
      RAMP:    pix = '{r: hcount[7:0], g: hcount[7:0], b: hcount[7:0]};
      default: pix = '0;
    endcase
    if (!(h_active && v_active)) begin
      pix = '0;
    end
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      vid.hsync       <= 1'b1;
      vid.vsync       <= 1'b1;
      vid.video_on    <= 1'b0;
      vid.frame_start <= 1'b0;
      vid.active_mode <= 2'd0;
      vid.red         <= '0;
      vid.green       <= '0;
      vid.blue        <= '0;
    end else begin
      vid.hsync       <= hsync_raw;
      vid.vsync       <= vsync_raw;
      vid.video_on    <= h_active && v_active;
      vid.frame_start <= (hcount == '0) && (vcount == '0);
      vid.active_mode <= cur_mode;
      vid.red         <= pix.r;
      vid.green       <= pix.g;
      vid.blue        <= pix.b;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen
module tb_vga_pattern_gen;

  logic clk_25 = 1'b0;
  logic n_rst_a = 1'b0;
  logic n_rst_bc = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   fail_prints = 0;

  always #5 clk_25 = ~clk_25;

  vga_pattern_gen_if vif_a ();
  vga_pattern_gen_if vif_b ();
  vga_pattern_gen_if vif_c ();

  // A: tiny 24x12 raster for frame-level behaviour.
  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .N_BARS(4), .CHECK_LOG2(2)
  ) dut_a (.clk_25(clk_25), .n_rst(n_rst_a), .vid(vif_a));

  // B: full 800-pixel lines, short 39-line frame.
  vga_pattern_gen #(
    .V_ACTIVE(36), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .N_BARS(4), .CHECK_LOG2(5)
  ) dut_b (.clk_25(clk_25), .n_rst(n_rst_bc), .vid(vif_b));

  // C: full 800-pixel lines, 7-line frame.
  vga_pattern_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .N_BARS(4), .CHECK_LOG2(5)
  ) dut_c (.clk_25(clk_25), .n_rst(n_rst_bc), .vid(vif_c));

  function automatic logic [23:0] pal(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected {hsync, vsync, video_on, frame_start, active_mode, rgb} after the
  // k-th clock since reset release (k=0: reset values).
  function automatic logic [29:0] exp_vec(input int ha, hf, hs, hb, va, vf, vs, vb,
                                          input int nb, cl, k, fm);
    int ht, vt, x, y;
    logic h, v, on, fs;
    logic [23:0] c;
    if (k == 0) return {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0};
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    x = (k - 1) % ht;
    y = ((k - 1) / ht) % vt;
    h = !(x >= ha + hf && x < ha + hf + hs);
    v = !(y >= va + vf && y < va + vf + vs);
    on = (x < ha) && (y < va);
    fs = (x == 0) && (y == 0);
    case (fm)
      0: c = pal(x / (ha / nb));
      1: c = pal(y / (va / nb));
      2: c = (((x >> cl) ^ (y >> cl)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: c = {3{8'(x % 256)}};
    endcase
    if (!on) c = 24'h0;
    return {h, v, on, fs, 2'(fm), c};
  endfunction

  task automatic cmp(input string nm, input logic [29:0] act, input logic [29:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
      end
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Model state: clocks since release and the mode each frame should use.
  int ka = 0, kbc = 0;
  int fm_a = 0, fm_b = 0, fm_c = 0;
  int pend_a = 0, pend_b = 0, pend_c = 0;

  initial forever begin
    @(posedge clk_25);
    if (!n_rst_a) begin
      ka = 0; fm_a = 0;
    end else begin
      ka++;
      if ((ka - 1) % 288 == 287) pend_a = int'(vif_a.mode_sel);
      if (ka > 1 && (ka - 1) % 288 == 0) fm_a = pend_a;
    end
    if (!n_rst_bc) begin
      kbc = 0; fm_b = 0; fm_c = 0;
    end else begin
      kbc++;
      if ((kbc - 1) % 31200 == 31199) pend_b = int'(vif_b.mode_sel);
      if (kbc > 1 && (kbc - 1) % 31200 == 0) fm_b = pend_b;
      if ((kbc - 1) % 5600 == 5599) pend_c = int'(vif_c.mode_sel);
      if (kbc > 1 && (kbc - 1) % 5600 == 0) fm_c = pend_c;
    end
  end

  initial forever begin
    @(negedge clk_25);
    cmp("model_a", {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.frame_start,
                    vif_a.active_mode, vif_a.red, vif_a.green, vif_a.blue},
        exp_vec(16, 2, 3, 3, 8, 1, 2, 1, 4, 2, n_rst_a ? ka : 0, fm_a));
    cmp("model_b", {vif_b.hsync, vif_b.vsync, vif_b.video_on, vif_b.frame_start,
                    vif_b.active_mode, vif_b.red, vif_b.green, vif_b.blue},
        exp_vec(640, 16, 96, 48, 36, 1, 1, 1, 4, 5, n_rst_bc ? kbc : 0, fm_b));
    cmp("model_c", {vif_c.hsync, vif_c.vsync, vif_c.video_on, vif_c.frame_start,
                    vif_c.active_mode, vif_c.red, vif_c.green, vif_c.blue},
        exp_vec(640, 16, 96, 48, 4, 1, 1, 1, 4, 5, n_rst_bc ? kbc : 0, fm_c));
  end

  task automatic wait_a(input int n);
    while (ka != n + 1) @(negedge clk_25);
  endtask

  task automatic wait_bc(input int n);
    while (kbc != n + 1) @(negedge clk_25);
  endtask

  function automatic logic [23:0] rgb_a();
    return {vif_a.red, vif_a.green, vif_a.blue};
  endfunction

  function automatic logic [23:0] rgb_b();
    return {vif_b.red, vif_b.green, vif_b.blue};
  endfunction

  task automatic seq_a();
    wait_a(17);  lit("a_hsync_x17", 32'(vif_a.hsync), 32'd1);
    wait_a(18);  lit("a_hsync_x18", 32'(vif_a.hsync), 32'd0);
    wait_a(20);  lit("a_hsync_x20", 32'(vif_a.hsync), 32'd0);
    wait_a(21);  lit("a_hsync_x21", 32'(vif_a.hsync), 32'd1);
    wait_a(100); vif_a.mode_sel = 2'd1;
    wait_a(101);
    lit("a_mode_held", 32'(vif_a.active_mode), 32'd0);
    lit("a_vbar_5_4", 32'(rgb_a()), 32'hFFFF00);
    wait_a(288);
    lit("a_fs_frame1", 32'(vif_a.frame_start), 32'd1);
    lit("a_mode_frame1", 32'(vif_a.active_mode), 32'd1);
    lit("a_hbar_0_0", 32'(rgb_a()), 32'hFFFFFF);
    wait_a(292); lit("a_hbar_4_0", 32'(rgb_a()), 32'hFFFFFF);
    wait_a(336); lit("a_hbar_0_2", 32'(rgb_a()), 32'hFFFF00);
    wait_a(504); lit("a_vsync_y9", 32'(vif_a.vsync), 32'd0);
    wait_a(552); lit("a_vsync_y11", 32'(vif_a.vsync), 32'd1);
    wait_a(703);
    #1 n_rst_a = 1'b0;
    #1;
    lit("a_rst_outputs", {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.frame_start,
                          vif_a.active_mode, rgb_a()}, {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0});
    repeat (2) @(posedge clk_25);
    #3 n_rst_a = 1'b1;
    wait_a(0);
    lit("a_fs_after_rst", 32'(vif_a.frame_start), 32'd1);
    lit("a_mode_after_rst", 32'(vif_a.active_mode), 32'd0);
    lit("a_rgb_after_rst", 32'(rgb_a()), 32'hFFFFFF);
    wait_a(288); lit("a_mode_next", 32'(vif_a.active_mode), 32'd1);
  endtask

  task automatic seq_bc();
    int hs_low, von_high;
    wait_bc(0);
    lit("b_fs_first", 32'(vif_b.frame_start), 32'd1);
    lit("b_rgb_0", 32'(rgb_b()), 32'hFFFFFF);
    hs_low = 0; von_high = 0;
    for (int p = 0; p < 800; p++) begin
      wait_bc(p);
      if (!vif_b.hsync) hs_low++;
      if (vif_b.video_on) von_high++;
      case (p)
        159: lit("b_px159", 32'(rgb_b()), 32'hFFFFFF);
        160: lit("b_px160", 32'(rgb_b()), 32'hFFFF00);
        320: lit("b_px320", 32'(rgb_b()), 32'h00FFFF);
        480: lit("b_px480", 32'(rgb_b()), 32'h00FF00);
        639: lit("b_px639", 32'(rgb_b()), 32'h00FF00);
        640: lit("b_px640", 32'({vif_b.video_on, rgb_b()}), 32'h0);
        655: lit("b_hs655", 32'(vif_b.hsync), 32'd1);
        656: lit("b_hs656", 32'(vif_b.hsync), 32'd0);
        751: lit("b_hs751", 32'(vif_b.hsync), 32'd0);
        752: lit("b_hs752", 32'(vif_b.hsync), 32'd1);
        default: ;
      endcase
    end
    lit("b_hs_low_count", 32'(hs_low), 32'd96);
    lit("b_von_count", 32'(von_high), 32'd640);
    wait_bc(800);
    lit("b_line1", {7'(vif_b.frame_start), rgb_b()}, 31'h0FFFFFF);
    wait_bc(1000);
    vif_b.mode_sel = 2'd2;
    vif_c.mode_sel = 2'd3;
    wait_bc(5900);
    lit("c_ramp_300", 32'({vif_c.red, vif_c.green, vif_c.blue}), 32'h2C2C2C);
    lit("c_mode", 32'(vif_c.active_mode), 32'd3);
    wait_bc(31200);
    lit("b_chk_0_0", {7'(vif_b.active_mode), rgb_b()}, 31'h2000000);
    wait_bc(31232); lit("b_chk_32_0", 32'(rgb_b()), 32'hFFFFFF);
    wait_bc(56800); lit("b_chk_0_32", 32'(rgb_b()), 32'hFFFFFF);
    wait_bc(56832); lit("b_chk_32_32", 32'(rgb_b()), 32'h000000);
  endtask

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=sequence_done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vif_a.mode_sel = 2'd0;
    vif_b.mode_sel = 2'd0;
    vif_c.mode_sel = 2'd0;
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    lit("a_reset_state", {vif_a.hsync, vif_a.vsync, vif_a.video_on, vif_a.frame_start,
                          vif_a.active_mode, rgb_a()}, {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 24'h0});
    @(posedge clk_25);
    #3;
    n_rst_a = 1'b1;
    n_rst_bc = 1'b1;
    fork
      seq_a();
      seq_bc();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
